// File: rtl/wb_arb2.sv
// wb_arb2: two-master to one-slave Wishbone arbiter with round-robin grant and whole-cycle ownership.
// Define ARB_TIMEOUT_EN to build the watchdog that terminates transfers the slave never acknowledges.
module wb_arb2 #(
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last_grant;
    logic [1:0] r_grant;
    logic       w_release;
    logic       w_stb_raw;
    logic       w_wd_fire;

    // Owner drops cyc: the slave is handed back on this edge
    always_comb begin
        w_release = 1'b0;
        case (r_state)
            ST_G0:   w_release = ~m0_cyc_i;
            ST_G1:   w_release = ~m1_cyc_i;
            default: w_release = 1'b0;
        endcase
    end

    // Ownership FSM; ties go to the master that was not served last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || r_last_grant)) begin
                        r_state <= ST_G0;
                        r_grant <= 2'b01;
                    end else if (m1_cyc_i) begin
                        r_state <= ST_G1;
                        r_grant <= 2'b10;
                    end else begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                    end
                end
                ST_G0: begin
                    if (w_release) begin
                        r_state      <= ST_IDLE;
                        r_grant      <= 2'b00;
                        r_last_grant <= 1'b0;
                    end else begin
                        r_state <= ST_G0;
                        r_grant <= 2'b01;
                    end
                end
                ST_G1: begin
                    if (w_release) begin
                        r_state      <= ST_IDLE;
                        r_grant      <= 2'b00;
                        r_last_grant <= 1'b1;
                    end else begin
                        r_state <= ST_G1;
                        r_grant <= 2'b10;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    // Slave-side request mux from the current owner
    always_comb begin
        s_adr_o   = 32'h0000_0000;
        s_dat_o   = 32'h0000_0000;
        s_sel_o   = 4'h0;
        s_we_o    = 1'b0;
        w_stb_raw = 1'b0;
        case (r_state)
            ST_G0: begin
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                s_sel_o   = m0_sel_i;
                s_we_o    = m0_we_i;
                w_stb_raw = m0_stb_i & m0_cyc_i;
            end
            ST_G1: begin
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                s_sel_o   = m1_sel_i;
                s_we_o    = m1_we_i;
                w_stb_raw = m1_stb_i & m1_cyc_i;
            end
            default: begin
                w_stb_raw = 1'b0;
            end
        endcase
    end

    assign s_stb_o = w_stb_raw & ~w_wd_fire;
    assign s_cyc_o = |r_grant;
    assign grant_o = r_grant;

    // Return path; a watchdog termination substitutes the error word for slave data
    always_comb begin
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = 32'h0000_0000;
        m1_dat_o = 32'h0000_0000;
        case (r_state)
            ST_G0: begin
                m0_ack_o = s_ack_i | w_wd_fire;
                m0_dat_o = w_wd_fire ? ERR_DATA : s_dat_i;
                m1_dat_o = s_dat_i;
            end
            ST_G1: begin
                m1_ack_o = s_ack_i | w_wd_fire;
                m1_dat_o = w_wd_fire ? ERR_DATA : s_dat_i;
                m0_dat_o = s_dat_i;
            end
            default: begin
                m0_ack_o = 1'b0;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT - 32'd1);

    logic [15:0] r_wd_cnt;
    logic        r_timeout;

    // Watchdog: counts unanswered strobe cycles, fires a one-cycle termination
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt  <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (r_state == ST_IDLE || w_release || s_ack_i) begin
                r_wd_cnt <= 16'd0;
            end else if (s_stb_o) begin
                if (r_wd_cnt == LP_WD_LAST) begin
                    r_wd_cnt  <= 16'd0;
                    r_timeout <= 1'b1;
                end else begin
                    r_wd_cnt <= r_wd_cnt + 16'd1;
                end
            end else begin
                r_wd_cnt <= r_wd_cnt;
            end
        end
    end

    assign w_wd_fire = r_timeout;
    assign timeout_o = r_timeout;
`else
    localparam logic [15:0] LP_UNUSED_TIMEOUT = 16'(TIMEOUT);

    assign w_wd_fire = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/wb_arb2.md
Name: wb_arb2

Overview:
- Two-master to one-slave Wishbone arbiter. It lets a hardware requester, e.g. a future sensor-poll engine, share a single peripheral (the i2c or SK6812RGBW slave port) with the LM32 data path coming out of conbus.
- Grant selection is round-robin. Once granted, a master holds the slave for its whole cycle (cyc held high).
- An optional watchdog terminates stuck slave transfers.

Parameters:
- TIMEOUT, 1023: cycles that stb may wait for ack before the watchdog terminates the transfer. Only used with ARB_TIMEOUT_EN. Range 2..65535.
- ERR_DATA, 32'hDEADBEEF: read data returned on a watchdog-terminated transfer.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- mN_adr_i (N=0,1)  input  32  master N address
- mN_dat_i  input  32  master N write data
- mN_dat_o  output  32  master N read data
- mN_sel_i  input  4  master N byte select
- mN_we_i  input  1  master N write enable
- mN_cyc_i  input  1  master N cycle request
- mN_stb_i  input  1  master N strobe
- mN_ack_o  output  1  master N acknowledge
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  output  32/32/4/1/1/1  slave-side bus
- s_dat_i  input  32  slave read data
- s_ack_i  input  1  slave acknowledge
- grant_o  output  2  one-hot current owner; bit0 = m0, bit1 = m1
- timeout_o  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- FSM states:
  - IDLE: no owner.
  - G0: m0 owns the slave.
  - G1: m1 owns the slave.
- Register last_grant: 0 = m0, 1 = m1.
- Reset (rst low, asynchronous, any cycle, including mid-transfer):
  - State goes to IDLE and last_grant to 1, so m0 wins the first tie.
  - grant_o, s_cyc_o, s_stb_o, s_we_o, mN_ack_o and timeout_o are all 0.
  - The watchdog counter goes to 0.
- IDLE transitions, evaluated on the clk edge:
  - Only m0_cyc_i high: go to G0.
  - Only m1_cyc_i high: go to G1.
  - Both high: grant the master that is not last_grant.
  - Neither high: stay in IDLE.
- Grant latency: one cycle from the rising edge of cyc to s_cyc_o high. The master's stb may be high during that wait; its ack stays 0.
- G0/G1:
  - The slave-side bus is a combinational mux of the owner's signals.
  - s_stb_o = owner stb AND owner cyc.
  - s_ack_i is routed combinationally to the owner's ack.
  - The non-owner's ack is forced to 0. Its dat_o is driven with s_dat_i (don't-care).
- Release:
  - When the owner drops cyc, the FSM returns to IDLE on that edge and sets last_grant = owner.
  - There is no direct G0 to G1 hop: one idle cycle is always inserted between owners.
- grant_o and s_cyc_o are driven from the registered state. There is no glitch path from the request inputs.
- Pipelined back-to-back strobes within one cyc are allowed. The grant is held for the whole cyc.
- An ack arriving in the same cycle the owner drops cyc is still delivered to that owner.
- Outside G0/G1:
  - All s_* outputs are 0.
  - mN_dat_o = 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter increments each cycle that s_stb_o is high and s_ack_i is low.
  - The counter clears on s_ack_i, on release, or on reset.
  - When the counter reaches TIMEOUT-1 with no ack:
    - The arbiter asserts the owner's ack for one cycle with dat_o = ERR_DATA.
    - timeout_o pulses for one cycle.
    - s_stb_o is forced low for that cycle.
    - The counter clears.
  - A late slave ack arriving after a timeout within the same owner cycle passes through as normal.
- Without the macro: there is no counter, timeout_o is tied to 0, and a stuck slave holds the grant indefinitely.

Test Plan:
- Reset, then raise m0 cyc/stb with a read at 0x70000004; the slave acks 2 cycles after s_stb_o with 0x000000A5 -> grant_o = 01 one cycle after cyc; m0_dat_o = 0xA5 with m0_ack_o; m1_ack_o stays 0.
- Raise m0 and m1 cyc in the same cycle after reset -> G0 first; after m0 releases, one IDLE cycle, then G1 (grant_o 01, 00, 10).
- m1 holds a 3-strobe pipelined burst while m0 requests -> m0 waits; grant stays 10 until m1 cyc drops, then becomes 01 two cycles later.
- Pull rst low while in G1 with s_stb_o high -> all outputs 0 immediately (asynchronous); after release, a fresh tie grants m0.
- With ARB_TIMEOUT_EN and TIMEOUT = 8, the slave never acks an m0 read -> m0_ack_o and timeout_o pulse 8 cycles after s_stb_o rises; m0_dat_o = 0xDEADBEEF.
- Without ARB_TIMEOUT_EN, run the same stimulus for 2000 cycles -> no ack, timeout_o = 0, grant_o stays 01.
